// File: rtl/recop_pio_pkg.sv
// Shared types and out_port field positions for the ReCOP-to-Nios PIO feeder.
package recop_pio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int DATA_LSB  = 0;
    localparam int VALID_BIT = 16;
    localparam int REQ_BIT   = 17;
    localparam int COUNT_LSB = 18;
    localparam int COUNT_W   = 6;
    localparam int OVF_BIT   = 24;
    localparam int PERR_BIT  = 25;

endpackage

// File: rtl/recop_pio_fifo.sv
// Single-clock FIFO holding ReCOP words; pointers wrap modulo DEPTH and a
// separate AW+1-bit count distinguishes full from empty.
module recop_pio_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the head is only consumed when count > 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/recop_pio_feeder.sv
// Feeds buffered ReCOP words to a Nios input PIO one at a time using a
// toggle request/acknowledge handshake driven back from a Nios output PIO.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | nothing presented; waits for the FIFO to hold a word
//   LOAD     | one cycle: pop head into data_q, raise valid, toggle req
//   WAIT_ACK | word presented; completes when ack_toggle matches req
module recop_pio_feeder
    import recop_pio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              ack_toggle,
    input  logic              clr_err,
    output logic [31:0]       out_port,
    output logic              overflow,
    output logic              proto_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic              present_valid_q;
    logic              req_q;

    logic [DATA_W-1:0] fifo_head;
    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              ack_match;
    logic              perr_event;

    // wr_ready follows the pre-pop count, so a push while full is dropped
    // even in a cycle that also pops.
    assign wr_ready   = !fifo_full;
    assign push_ok    = wr_valid && !fifo_full;
    assign drop       = wr_valid && fifo_full;
    assign pop        = (state_q == LOAD);
    assign ack_match  = (ack_toggle == req_q);
    assign perr_event = ((state_q == IDLE) || (state_q == LOAD)) && !ack_match;

    recop_pio_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = (!fifo_empty || push_ok) ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q          <= '0;
            present_valid_q <= 1'b0;
            req_q           <= 1'b0;
        end else if (state_q == LOAD) begin
            data_q          <= fifo_head;
            present_valid_q <= 1'b1;
            req_q           <= ~req_q;
        end else if ((state_q == WAIT_ACK) && ack_match) begin
            present_valid_q <= 1'b0;
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= drop | (overflow & ~clr_err);
            proto_err <= perr_event | (proto_err & ~clr_err);
        end
    end

    always_comb begin
        out_port                          = '0;
        out_port[DATA_LSB +: DATA_W]      = data_q;
        out_port[VALID_BIT]               = present_valid_q;
        out_port[REQ_BIT]                 = req_q;
        out_port[COUNT_LSB +: COUNT_W]    = COUNT_W'(fifo_count);
        out_port[OVF_BIT]                 = overflow;
        out_port[PERR_BIT]                = proto_err;
    end

endmodule

// File: tb/tb_recop_pio_feeder.sv
// Self-checking bench for recop_pio_feeder: directed scenarios plus a
// randomized push/ack stream checked against a word-queue reference model.
module tb_recop_pio_feeder;
    import recop_pio_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [15:0] d;
        int          e;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        ack_toggle = 1'b0;
    logic        clr_err = 1'b0;
    logic        wr_ready;
    logic [31:0] out_port;
    logic        overflow;
    logic        proto_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic req_m = 1'b0;

    always #5 clk = ~clk;

    recop_pio_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ack_toggle (ack_toggle),
        .clr_err    (clr_err),
        .out_port   (out_port),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_valid = 1'b0; ack_toggle = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        checks++;
        if (out_port !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_out_port: got %h expected %h", out_port, 32'h0);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
        checks++;
        if ({overflow, proto_err} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {overflow, proto_err});
        end
        req_m = 1'b0;
    endtask

    task automatic test_single_word();
        wr_data = 16'hA5A5; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        step();
        req_m = ~req_m;
        checks++;
        if (out_port !== 32'h0003_A5A5) begin
            errors++; $display("FAIL single_present: got %h expected %h", out_port, 32'h0003_A5A5);
        end
        repeat (5) step();
        checks++;
        if (out_port !== 32'h0003_A5A5) begin
            errors++; $display("FAIL single_hold: got %h expected %h", out_port, 32'h0003_A5A5);
        end
        ack_toggle = req_m;
        step();
        checks++;
        if (out_port !== 32'h0002_A5A5) begin
            errors++; $display("FAIL single_ack: got %h expected %h", out_port, 32'h0002_A5A5);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL single_proto: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_overflow_order();
        for (int i = 1; i <= 10; i++) begin
            wr_data = 16'(i); wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || out_port[OVF_BIT] !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %b/%b expected 1/1", overflow, out_port[OVF_BIT]);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_wr_ready: got %b expected 0", wr_ready);
        end
        checks++;
        if (out_port[23:18] !== 6'd8) begin
            errors++; $display("FAIL ovf_count: got %0d expected 8", out_port[23:18]);
        end
        for (int w = 1; w <= 9; w++) begin
            int n = 0;
            while (!(out_port[VALID_BIT] === 1'b1 && out_port[REQ_BIT] !== ack_toggle) && n < 10) begin
                step();
                n++;
            end
            checks++;
            if (n >= 10) begin
                errors++; $display("FAIL drain_timeout: word %0d not presented within %0d cycles", w, n);
            end
            req_m = ~req_m;
            checks++;
            if (out_port[15:0] !== 16'(w) || out_port[REQ_BIT] !== req_m) begin
                errors++;
                $display("FAIL drain_word: got data %h req %b expected data %h req %b",
                         out_port[15:0], out_port[REQ_BIT], 16'(w), req_m);
            end
            ack_toggle = req_m;
            step();
        end
        step();
        checks++;
        if (out_port[VALID_BIT] !== 1'b0 || out_port[23:18] !== 6'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got valid %b count %0d ready %b expected 0 0 1",
                     out_port[VALID_BIT], out_port[23:18], wr_ready);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_push_with_ack();
        logic [31:0] exp_w;
        wr_data = 16'h1234; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        step();
        req_m = ~req_m;
        exp_w = {8'h00, 6'd0, req_m, 1'b1, 16'h1234};
        checks++;
        if (out_port !== exp_w) begin
            errors++; $display("FAIL pa_first: got %h expected %h", out_port, exp_w);
        end
        wr_data = 16'h5678; wr_valid = 1'b1; ack_toggle = req_m;
        step();
        wr_valid = 1'b0;
        exp_w = {8'h00, 6'd1, req_m, 1'b0, 16'h1234};
        checks++;
        if (out_port !== exp_w) begin
            errors++; $display("FAIL pa_load: got %h expected %h", out_port, exp_w);
        end
        step();
        req_m = ~req_m;
        exp_w = {8'h00, 6'd0, req_m, 1'b1, 16'h5678};
        checks++;
        if (out_port !== exp_w) begin
            errors++; $display("FAIL pa_second: got %h expected %h", out_port, exp_w);
        end
        ack_toggle = req_m;
        step();
        checks++;
        if (out_port[VALID_BIT] !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL pa_done: got valid %b perr %b expected 0 0", out_port[VALID_BIT], proto_err);
        end
    endtask

    task automatic test_proto_err_clr();
        ack_toggle = ~req_m;
        step();
        ack_toggle = req_m;
        checks++;
        if (proto_err !== 1'b1 || out_port[PERR_BIT] !== 1'b1) begin
            errors++; $display("FAIL perr_set: got %b/%b expected 1/1", proto_err, out_port[PERR_BIT]);
        end
        step();
        checks++;
        if (proto_err !== 1'b1 || out_port[VALID_BIT] !== 1'b0) begin
            errors++;
            $display("FAIL perr_sticky: got perr %b valid %b expected 1 0", proto_err, out_port[VALID_BIT]);
        end
        for (int i = 0; i < 10; i++) begin
            wr_data = 16'(16'h0020 + i); wr_valid = 1'b1;
            clr_err = (i == 9);
            step();
        end
        wr_valid = 1'b0; clr_err = 1'b0;
        req_m = ~req_m;
        checks++;
        if (overflow !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_set: got ovf %b perr %b expected 1 0", overflow, proto_err);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clr_ovf: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 32'h0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async: got %h ready %b expected 0 1", out_port, wr_ready);
        end
        step();
        ack_toggle = 1'b0;
        reset_n = 1'b1;
        req_m = 1'b0;
        step();
        step();
        checks++;
        if (out_port !== 32'h0 || {overflow, proto_err} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_after: got %h flags %b expected 0 00", out_port, {overflow, proto_err});
        end
    endtask

    // Reference: each word is presented at push_edge+2, or one edge after the
    // previous completion if it was already pushed by then; FIFO count equals
    // the number of accepted but not-yet-presented words.
    task automatic test_random(input int ncyc, input int drain);
        word_t       q[$];
        word_t       w;
        logic        awaiting = 1'b0;
        int          delay = 0;
        int          last_ack = -100;
        logic        exp_req = 1'b0;
        logic [15:0] cur = '0;
        int          exp_edge;
        for (int i = 0; i < ncyc + drain; i++) begin
            if (awaiting) begin
                if (delay == 0) begin
                    ack_toggle = exp_req;
                    awaiting = 1'b0;
                    last_ack = cyc + 1;
                end else begin
                    delay--;
                end
            end
            if (i < ncyc && q.size() < DEPTH && ($urandom % 2) == 1) begin
                w.d = 16'($urandom);
                w.e = cyc + 1;
                q.push_back(w);
                wr_data = w.d;
                wr_valid = 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
            step();
            if (!awaiting && q.size() > 0) begin
                exp_edge = (q[0].e <= last_ack) ? last_ack + 1 : q[0].e + 2;
                if (cyc == exp_edge) begin
                    exp_req = ~exp_req;
                    cur = q[0].d;
                    void'(q.pop_front());
                    awaiting = 1'b1;
                    delay = $urandom_range(4, 0);
                end
            end
            checks++;
            if (out_port[VALID_BIT] !== awaiting) begin
                errors++; $display("FAIL rnd_valid: cyc %0d got %b expected %b", cyc, out_port[VALID_BIT], awaiting);
            end
            if (awaiting) begin
                checks++;
                if (out_port[15:0] !== cur || out_port[REQ_BIT] !== exp_req) begin
                    errors++;
                    $display("FAIL rnd_word: cyc %0d got data %h req %b expected data %h req %b",
                             cyc, out_port[15:0], out_port[REQ_BIT], cur, exp_req);
                end
            end
            checks++;
            if (out_port[23:18] !== 6'(q.size()) || wr_ready !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rnd_count: cyc %0d got count %0d ready %b expected count %0d",
                         cyc, out_port[23:18], wr_ready, q.size());
            end
            checks++;
            if ({overflow, proto_err} !== 2'b00) begin
                errors++; $display("FAIL rnd_flags: cyc %0d got %b expected 00", cyc, {overflow, proto_err});
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (q.size() != 0 || awaiting) begin
            errors++; $display("FAIL rnd_drain: %0d words left, awaiting %b expected 0 0", q.size(), awaiting);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_overflow_order();
        test_push_with_ack();
        test_proto_err_clr();
        test_reset_mid();
        test_random(1500, 150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
